// File: rtl/pipe_pkg.sv
// Shared widths, ALU opcodes and operand-select encodings for the ID/EX stage.
package pipe_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int ALUC_W  = 4;
  localparam int SHAMT_W = 5;

  // LUI and SLL ignore aluc[0]; the even encoding is the canonical one.
  localparam logic [ALUC_W-1:0] ALUC_ADDU = 4'b0000;
  localparam logic [ALUC_W-1:0] ALUC_SUBU = 4'b0001;
  localparam logic [ALUC_W-1:0] ALUC_ADD  = 4'b0010;
  localparam logic [ALUC_W-1:0] ALUC_SUB  = 4'b0011;
  localparam logic [ALUC_W-1:0] ALUC_AND  = 4'b0100;
  localparam logic [ALUC_W-1:0] ALUC_OR   = 4'b0101;
  localparam logic [ALUC_W-1:0] ALUC_XOR  = 4'b0110;
  localparam logic [ALUC_W-1:0] ALUC_NOR  = 4'b0111;
  localparam logic [ALUC_W-1:0] ALUC_LUI  = 4'b1000;
  localparam logic [ALUC_W-1:0] ALUC_SLTU = 4'b1010;
  localparam logic [ALUC_W-1:0] ALUC_SLT  = 4'b1011;
  localparam logic [ALUC_W-1:0] ALUC_SRA  = 4'b1100;
  localparam logic [ALUC_W-1:0] ALUC_SRL  = 4'b1101;
  localparam logic [ALUC_W-1:0] ALUC_SLL  = 4'b1110;

  typedef enum logic {
    A_SEL_RS    = 1'b0,
    A_SEL_SHAMT = 1'b1
  } a_sel_e;

  typedef enum logic {
    B_SEL_RT  = 1'b0,
    B_SEL_IMM = 1'b1
  } b_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Single-operand forward selector: EX/MEM result, then MEM/WB result, then register-file data.
module fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1
) (
  input  logic [REG_AW-1:0] src_idx,
  input  logic [DATA_W-1:0] src_data,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [DATA_W-1:0] mwb_result,
  output logic [DATA_W-1:0] fwd_data
);
  import pipe_pkg::*;

  logic exm_hit;
  logic mwb_hit;

  // Register 0 is hardwired to zero, so a write targeting it must never be forwarded.
  always_comb begin
    exm_hit  = exm_reg_write && (exm_rd != '0) && (exm_rd == src_idx);
    mwb_hit  = mwb_reg_write && (mwb_rd != '0) && (mwb_rd == src_idx);
    fwd_data = src_data;
    if (FWD_EN != 0) begin
      if (exm_hit) begin
        fwd_data = exm_result;
      end else if (mwb_hit) begin
        fwd_data = mwb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with ALU operand forwarding, load-use bubble insertion,
// branch flush and downstream freeze.
module id_ex_operand_stage #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_AW = pipe_pkg::REG_AW,
  parameter int ALUC_W = pipe_pkg::ALUC_W,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic              id_a_sel,
  input  logic              id_b_sel,
  input  logic [ALUC_W-1:0] id_aluc,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic              mem_stall,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [DATA_W-1:0] mwb_result,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [ALUC_W-1:0] ex_aluc,
  output logic [DATA_W-1:0] ex_alu_a,
  output logic [DATA_W-1:0] ex_alu_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              hazard_stall
);
  import pipe_pkg::*;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        shamt;
    logic              a_sel;
    logic              b_sel;
    logic [ALUC_W-1:0] aluc;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } ex_reg_t;

  ex_reg_t ex_q;
  ex_reg_t ex_d;
  ex_reg_t id_fields;

  logic rs_dep;
  logic rt_dep;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // A load in EX cannot forward yet, so a dependent instruction in ID must wait one cycle.
  always_comb begin
    rs_dep       = id_uses_rs && (id_rs == ex_q.rd);
    rt_dep       = id_uses_rt && (id_rt == ex_q.rd);
    hazard_stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                   (rs_dep || rt_dep) && !flush;
  end

  always_comb begin
    id_fields = '{valid: id_valid, pc: id_pc, rs: id_rs, rt: id_rt, rd: id_rd,
                  rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm,
                  shamt: id_shamt, a_sel: id_a_sel, b_sel: id_b_sel, aluc: id_aluc,
                  reg_write: id_reg_write, mem_read: id_mem_read,
                  mem_write: id_mem_write};
    ex_d = ex_q;
    if (mem_stall) begin
      ex_d = ex_q;
    end else if (flush || hazard_stall) begin
      ex_d = '0;
    end else begin
      ex_d = id_fields;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_rs (
    .src_idx       (ex_q.rs),
    .src_data      (ex_q.rs_data),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .fwd_data      (fwd_rs)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_rt (
    .src_idx       (ex_q.rt),
    .src_data      (ex_q.rt_data),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .fwd_data      (fwd_rt)
  );

  // Store data always takes forwarded rt, even when the ALU b input is the immediate.
  always_comb begin
    ex_valid      = ex_q.valid;
    ex_pc         = ex_q.pc;
    ex_aluc       = ex_q.aluc;
    ex_rd         = ex_q.rd;
    ex_reg_write  = ex_q.valid && ex_q.reg_write;
    ex_mem_read   = ex_q.valid && ex_q.mem_read;
    ex_mem_write  = ex_q.valid && ex_q.mem_write;
    ex_alu_a      = (ex_q.a_sel == A_SEL_SHAMT) ? DATA_W'(ex_q.shamt) : fwd_rs;
    ex_alu_b      = (ex_q.b_sel == B_SEL_IMM) ? ex_q.imm : fwd_rt;
    ex_store_data = fwd_rt;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register feeding the EX-stage ALU.
- Latches decoded operands and control, then selects ALU a/b with EX/MEM and MEM/WB forwarding.
- Detects load-use hazards, inserts one bubble, and raises a stall to IF/ID.
- Handles branch flush and downstream freeze.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register-index width
ALUC_W, 4, ALU opcode width
FWD_EN, 1, 1 enables forwarding; 0 passes register-file data unmodified

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_pc  in  DATA_W  instruction PC
id_rs, id_rt, id_rd  in  REG_AW  source indices, destination index
id_uses_rs, id_uses_rt  in  1  instruction reads rs / rt
id_rs_data, id_rt_data  in  DATA_W  register-file read data
id_imm  in  DATA_W  pre-extended immediate
id_shamt  in  5  shift amount field
id_a_sel  in  1  0 = rs, 1 = zero-extended shamt
id_b_sel  in  1  0 = rt, 1 = imm
id_aluc  in  ALUC_W  ALU opcode
id_reg_write, id_mem_read, id_mem_write  in  1  control
flush  in  1  kill the instruction entering EX
mem_stall  in  1  freeze from downstream
exm_reg_write  in  1  EX/MEM writes a register
exm_rd  in  REG_AW  EX/MEM destination
exm_result  in  DATA_W  EX/MEM ALU result
mwb_reg_write  in  1  MEM/WB writes a register
mwb_rd  in  REG_AW  MEM/WB destination
mwb_result  in  DATA_W  MEM/WB writeback data
ex_valid  out  1  EX holds a real instruction
ex_pc  out  DATA_W  registered PC
ex_aluc  out  ALUC_W  to ALU aluc
ex_alu_a, ex_alu_b  out  DATA_W  to ALU a, b
ex_store_data  out  DATA_W  forwarded rt, for stores
ex_rd  out  REG_AW  registered destination
ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control, all gated by ex_valid
hazard_stall  out  1  hold PC and IF/ID this cycle

Behaviour:
- Clocking: one clock domain, clk; synchronous active-low reset rst_n.
- Reset, on a clock edge with rst_n=0:
  - all registered fields cleared to 0, so ex_valid=0 and every control output is 0;
  - ex_alu_a, ex_alu_b and ex_store_data read 0;
  - hazard_stall=0.
- Register update priority, per edge, highest first:
  - rst_n=0: clear;
  - mem_stall=1: hold every field; flush and bubble are ignored, so upstream must hold flush until mem_stall falls;
  - flush=1: load a bubble (valid=0, rd=0, controls=0);
  - hazard_stall=1: load a bubble;
  - otherwise: load all id_* fields, with valid=id_valid.
- Load-use hazard, combinational from registered state:
  - hazard_stall = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)) & ~flush;
  - exactly one bubble is inserted; the next cycle the load sits in EX/MEM and EX holds the bubble, so hazard_stall falls;
  - the dependent instruction enters EX as the load reaches MEM/WB, and its data arrives via MWB forwarding.
- Forwarding, combinational, applied to the registered rs and rt operands:
  - EXM match: exm_reg_write & exm_rd != 0 & exm_rd == reg;
  - MWB match: the same test against mwb_reg_write / mwb_rd;
  - priority: EXM, then MWB, then the registered data;
  - register 0 is never forwarded;
  - with FWD_EN=0, the registered data is always used.
- Operand selection:
  - ex_alu_a = a_sel ? {27'b0, shamt} : fwd_rs;
  - ex_alu_b = b_sel ? imm : fwd_rt;
  - ex_store_data = fwd_rt, regardless of b_sel.
- Bubble state: all outputs carry the registered zeros, except ex_alu_a/b, which still pass through the forwarding muxes. This is harmless because every control output is 0.
- Latency: an accepted ID instruction appears at the ex_* outputs one cycle later.

Decomposition:
- Shared package pipe_pkg:
  - DATA_W, REG_AW, ALUC_W;
  - the ALUC opcode constants (ADDU=0000, SUBU=0001, ADD=0010, SUB=0011, AND=0100, OR=0101, XOR=0110, NOR=0111, LUI=100x, SLTU=1010, SLT=1011, SRA=1100, SRL=1101, SLL=111x);
  - the A_SEL/B_SEL encodings.
- One sub-module, fwd_mux: a single-operand forward selector, instantiated twice (rs and rt).

Test Plan:
- Reset and single instruction: hold rst_n=0 for 2 cycles -> ex_valid=0, all controls 0, hazard_stall=0. Then present ADD r3=r1+r2 with rs_data=5, rt_data=7 -> next cycle ex_alu_a=5, ex_alu_b=7, ex_aluc=0010, ex_rd=3.
- EX/MEM forwarding: EX holds rs=r1; exm_reg_write=1, exm_rd=1, exm_result=0x11; mwb_reg_write=1, mwb_rd=1, mwb_result=0x22 -> ex_alu_a=0x11. Then drop exm_reg_write -> ex_alu_a=0x22.
- Register 0 guard: exm_rd=0, exm_reg_write=1, exm_result=0xFFFF, EX rs=r0 with rs_data=0 -> ex_alu_a=0.
- Load-use: LW r4 loaded into EX, then ID presents ADD using r4 -> hazard_stall=1 for exactly one cycle and the next EX is a bubble (ex_valid=0). The ADD then enters EX; with mwb_rd=4, mwb_result=0x99 -> ex_alu_a=0x99.
- Shift and immediate selection: a_sel=1, shamt=5, b_sel=1, imm=0xFFFF_FF80 -> ex_alu_a=5, ex_alu_b=0xFFFF_FF80. ex_store_data still equals the forwarded rt.
- Stall vs flush: mem_stall=1 and flush=1 together -> all outputs unchanged. Release mem_stall with flush=1 -> bubble loaded, ex_reg_write=0.
